// File: rtl/mask_rand_gen_if.sv
// Seed / randomness handshake between the DIZY masking core and its
// fresh-randomness source.
interface mask_rand_gen_if #(
  parameter int RW = 8
);
  logic          seed_valid;
  logic [63:0]   seed;
  logic          seed_ready;
  logic          en;
  logic [RW-1:0] z;
  logic          z_valid;

  modport master (
    output seed_valid, seed, en,
    input  seed_ready, z, z_valid
  );

  modport slave (
    input  seed_valid, seed, en,
    output seed_ready, z, z_valid
  );
endinterface

// File: rtl/mask_rand_gen.sv
// Seeded 64-bit Fibonacci LFSR delivering RW fresh bits per cycle to the
// masked AND-XOR gates, with a mandatory warm-up after every seed load.
module mask_rand_gen #(
  parameter int RW     = 8,
  parameter int WARMUP = 64
) (
  input logic            clk,
  input logic            rst,
  mask_rand_gen_if.slave bus
);
  localparam int            CW       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WARMUP - 1);

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  state_t        r_state;
  logic [63:0]   r_lfsr;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_z;
  logic          r_z_valid;
  logic          r_seed_ready;

  logic [63:0]   w_upd;
  logic [63:0]   w_seed_ld;
  logic          w_accept;

  // RW steps of x^64+x^63+x^61+x^60+1, unrolled into one update
  always_comb begin
    w_upd = r_lfsr;
    for (int i = 0; i < RW; i++)
      w_upd = {w_upd[62:0], w_upd[63] ^ w_upd[62] ^ w_upd[60] ^ w_upd[59]};
  end

  // an all-zero state would lock the LFSR forever
  assign w_seed_ld = (bus.seed == 64'h0) ? 64'h1 : bus.seed;
  assign w_accept  = bus.seed_valid & r_seed_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lfsr       <= 64'h0;
      r_cnt        <= '0;
      r_z          <= '0;
      r_z_valid    <= 1'b0;
      r_seed_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (w_accept) begin
            r_lfsr       <= w_seed_ld;
            r_cnt        <= '0;
            r_state      <= WARM;
            r_seed_ready <= 1'b0;
            r_z_valid    <= 1'b0;
            r_z          <= '0;
          end else begin
            r_seed_ready <= 1'b1;
            if (r_state == RUN && bus.en) begin
              r_lfsr <= w_upd;
              r_z    <= w_upd[RW-1:0];
            end
          end
        end
        WARM: begin
          r_lfsr <= w_upd;
          if (r_cnt == CNT_LAST) begin
            r_state      <= RUN;
            r_z          <= w_upd[RW-1:0];
            r_z_valid    <= 1'b1;
            r_seed_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_z          <= '0;
          r_z_valid    <= 1'b0;
          r_seed_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.z          = r_z;
  assign bus.z_valid    = r_z_valid;
  assign bus.seed_ready = r_seed_ready;
endmodule

// File: tb/tb_mask_rand_gen.sv
// Directed + randomized checks of mask_rand_gen against a polynomial-level
// LFSR model, on a tiny (RW=1, WARMUP=1) and a default-sized instance.
module tb_mask_rand_gen;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000; // bits 63,62,60,59

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mask_rand_gen_if #(.RW(1)) bus_a ();
  mask_rand_gen_if #(.RW(8)) bus_b ();

  mask_rand_gen #(.RW(1), .WARMUP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mask_rand_gen #(.RW(8), .WARMUP(64)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  function automatic logic [63:0] adv(input logic [63:0] s, input int n);
    for (int i = 0; i < n; i++) s = {s[62:0], ^(s & TAPS)};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [63:0] m, seed;
  logic [7:0]  held;
  logic        e;

  initial begin
    bus_a.seed_valid = 0; bus_a.seed = '0; bus_a.en = 0;
    bus_b.seed_valid = 0; bus_b.seed = '0; bus_b.en = 0;
    @(negedge clk);
    chk("rst_ready_a", 64'(bus_a.seed_ready), 0);
    chk("rst_zv_b", 64'(bus_b.z_valid), 0);
    tick();
    chk("rst_z_b", 64'(bus_b.z), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready_a", 64'(bus_a.seed_ready), 1);
      chk("idle_ready_b", 64'(bus_b.seed_ready), 1);
      chk("idle_zv_b", 64'(bus_b.z_valid), 0);
      chk("idle_z_b", 64'(bus_b.z), 0);
    end

    // tiny instance: first word
    bus_a.seed_valid = 1; bus_a.seed = 64'h8000_0000_0000_0000;
    tick();
    bus_a.seed_valid = 0;
    chk("a_warm_ready", 64'(bus_a.seed_ready), 0);
    chk("a_warm_zv", 64'(bus_a.z_valid), 0);
    m = adv(64'h8000_0000_0000_0000, 1);
    tick();
    chk("a_first_zv", 64'(bus_a.z_valid), 1);
    chk("a_first_z", 64'(bus_a.z), 64'(m[0]));
    chk("a_first_z_const", 64'(bus_a.z), 1);
    bus_a.en = 1;
    tick();
    bus_a.en = 0;
    m = adv(m, 1);
    chk("a_en_z", 64'(bus_a.z), 64'(m[0]));
    chk("a_en_z_const", 64'(bus_a.z), 0);

    // zero seed loads 1, then 1000 updates
    bus_a.seed_valid = 1; bus_a.seed = 64'h0;
    tick();
    bus_a.seed_valid = 0;
    chk("a_zero_warm_zv", 64'(bus_a.z_valid), 0);
    tick();
    m = adv(64'h1, 1);
    chk("a_zero_zv", 64'(bus_a.z_valid), 1);
    chk("a_zero_z", 64'(bus_a.z), 0);
    bus_a.en = 1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      m = adv(m, 1);
      chk("a_run_z", 64'(bus_a.z), 64'(m[0]));
    end
    bus_a.en = 0;

    // default instance: warm-up length and 512-step word
    seed = {$urandom, $urandom};
    bus_b.seed_valid = 1; bus_b.seed = seed;
    tick();
    bus_b.seed_valid = 0;
    for (int i = 0; i < 64; i++) begin
      chk("b_warm_ready", 64'(bus_b.seed_ready), 0);
      chk("b_warm_zv", 64'(bus_b.z_valid), 0);
      chk("b_warm_z", 64'(bus_b.z), 0);
      tick();
    end
    m = adv((seed == 0) ? 64'h1 : seed, 512);
    chk("b_first_zv", 64'(bus_b.z_valid), 1);
    chk("b_first_ready", 64'(bus_b.seed_ready), 1);
    chk("b_first_z", 64'(bus_b.z), 64'(m[7:0]));

    // en hold, then three updates
    held = bus_b.z;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_z", 64'(bus_b.z), 64'(m[7:0]));
    end
    bus_b.en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      m = adv(m, 8);
      chk("b_step_z", 64'(bus_b.z), 64'(m[7:0]));
    end

    // re-seed with en in the same cycle; en stays high through warm-up
    seed = {$urandom, $urandom};
    bus_b.seed_valid = 1; bus_b.seed = seed;
    tick();
    bus_b.seed_valid = 0;
    chk("b_reseed_zv", 64'(bus_b.z_valid), 0);
    chk("b_reseed_z", 64'(bus_b.z), 0);
    chk("b_reseed_ready", 64'(bus_b.seed_ready), 0);
    for (int i = 1; i < 64; i++) begin
      tick();
      chk("b_rewarm_zv", 64'(bus_b.z_valid), 0);
    end
    bus_b.en = 0;
    tick();
    m = adv((seed == 0) ? 64'h1 : seed, 512);
    chk("b_rerun_zv", 64'(bus_b.z_valid), 1);
    chk("b_rerun_z", 64'(bus_b.z), 64'(m[7:0]));

    // random en pattern
    for (int i = 0; i < 60; i++) begin
      e = 1'($urandom_range(1));
      bus_b.en = e;
      tick();
      if (e) m = adv(m, 8);
      chk("b_rand_z", 64'(bus_b.z), 64'(m[7:0]));
      chk("b_rand_zv", 64'(bus_b.z_valid), 1);
    end
    bus_b.en = 0;

    // reset mid-warm, with a seed offered on the reset edge
    bus_b.seed_valid = 1; bus_b.seed = {$urandom, $urandom};
    tick();
    bus_b.seed_valid = 0;
    repeat (10) tick();
    rst = 1; bus_b.seed_valid = 1; bus_b.en = 1;
    tick();
    chk("b_rst_ready", 64'(bus_b.seed_ready), 0);
    chk("b_rst_zv", 64'(bus_b.z_valid), 0);
    chk("b_rst_z", 64'(bus_b.z), 0);
    rst = 0; bus_b.seed_valid = 0; bus_b.en = 0;
    repeat (2) tick();
    chk("b_post_ready", 64'(bus_b.seed_ready), 1);
    chk("b_post_zv", 64'(bus_b.z_valid), 0);
    chk("b_post_z", 64'(bus_b.z), 0);
    chk("b_held_nonzero_run", 64'(held == m[7:0] && held != held), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
